reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_if.sv | 39 +++
 rtl/reg_bank_cell.sv | 25 ++
 rtl/reg_bank.sv | 143 ++++++++++++++
 tb/tb_reg_bank.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the reg_bank block.
// Optional feature macro used elsewhere in this block: REG_BANK_MAX_EN.
package reg_bank_pkg;

  typedef enum logic {
    StFill,
    StDrain
  } state_e;

  localparam int unsigned MaxWidth = 64;

  // Most-negative two's complement value for a given width, sign-extended to
  // MaxWidth bits; callers truncate to their own width.
  function automatic logic [MaxWidth-1:0] most_neg(input int unsigned width);
    return ~((64'd1 << (width - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: control/data bus of reg_bank.
// max_out only exists when REG_BANK_MAX_EN is defined.
interface reg_bank_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) ();
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                         clr;
  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] wr_data;
  logic                         rd_en;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         full;
  logic                         empty;
  logic [CntW-1:0]              count;
  logic                         wr_err;
`ifdef REG_BANK_MAX_EN
  logic signed [DATA_WIDTH-1:0] max_out;
`endif

  modport master (
    output clr, wr_en, wr_data, rd_en,
`ifdef REG_BANK_MAX_EN
    input  max_out,
`endif
    input  rd_data, rd_valid, full, empty, count, wr_err
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
`ifdef REG_BANK_MAX_EN
    output max_out,
`endif
    output rd_data, rd_valid, full, empty, count, wr_err
  );

endinterface

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one signed storage entry with load enable, async reset to 0.
module reg_bank_cell #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic signed [DATA_WIDTH-1:0] d_i,
  output logic signed [DATA_WIDTH-1:0] q_o
);

  logic signed [DATA_WIDTH-1:0] q_q;

  // Entry register, loaded only on an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: fill-then-drain register bank. Writes are accepted while filling
// until DEPTH entries are held, then reads drain them in order.
// Define REG_BANK_MAX_EN to add a running signed maximum output (max_out).
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input logic       clk,
  input logic       rst,
  reg_bank_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  state_e                       state_q, state_d;
  logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]              count_q, count_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         wr_err_q, wr_err_d;
  logic [DEPTH-1:0]             cell_load;
  logic signed [DATA_WIDTH-1:0] entry [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : gen_cells
    reg_bank_cell #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .load_i(cell_load[i]),
      .d_i   (bus.wr_data),
      .q_o   (entry[i])
    );
  end

  // Next-state: clr wins, then only the operation legal in the current state.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_err_d   = 1'b0;
    cell_load  = '0;
    if (bus.clr) begin
      state_d  = StFill;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (bus.wr_en) begin
            cell_load[wr_ptr_q] = 1'b1;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
            count_d             = count_q + CntW'(1);
            if (count_q == CntW'(DEPTH - 1)) begin
              state_d  = StDrain;
              wr_ptr_d = '0;
            end
          end
        end
        StDrain: begin
          wr_err_d = bus.wr_en;
          if (bus.rd_en) begin
            rd_data_d  = entry[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
            count_d    = count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
              state_d  = StFill;
              rd_ptr_d = '0;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.count    = count_q;
  assign bus.full     = (state_q == StDrain);
  assign bus.empty    = (count_q == '0);

`ifdef REG_BANK_MAX_EN
  localparam logic signed [DATA_WIDTH-1:0] MostNeg = DATA_WIDTH'(most_neg(DATA_WIDTH));

  logic signed [DATA_WIDTH-1:0] max_q, max_d;

  // Running maximum; the first write of a fill (count 0) loads unconditionally.
  always_comb begin
    max_d = max_q;
    if (bus.clr) begin
      max_d = MostNeg;
    end else if ((state_q == StFill) && bus.wr_en) begin
      if ((count_q == '0) || (bus.wr_data > max_q)) begin
        max_d = bus.wr_data;
      end
    end
  end

  // Maximum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= MostNeg;
    end else begin
      max_q <= max_d;
    end
  end

  assign bus.max_out = max_q;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed test of reg_bank (DATA_WIDTH=16, DEPTH=4).
// Read expectations go into a queue; a monitor pops them on rd_valid.
// Define REG_BANK_MAX_EN to also exercise max_out.
module tb_reg_bank;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_bank_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  reg_bank #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rd_valid: got rd_data %0d, expected no read", int'(bus.rd_data));
      end else begin
        check("rd_data", int'(bus.rd_data), exp_q.pop_front());
      end
    end
  end

  task automatic do_write(input int v);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'(v);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(input int exp);
    bus.rd_en = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset values
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_wr_err", int'(bus.wr_err), 0);
    rst = 1'b0;

    // Basic fill and drain
    do_write(5);
    do_write(-3);
    do_write(7);
    check("fill3_count", int'(bus.count), 3);
    check("fill3_full", int'(bus.full), 0);
    do_write(1);
    check("fill4_full", int'(bus.full), 1);
    check("fill4_count", int'(bus.count), 4);
    check("fill4_empty", int'(bus.empty), 0);
    do_read(5);
    do_read(-3);
    do_read(7);
    do_read(1);
    @(negedge clk);
    check("drained_empty", int'(bus.empty), 1);
    check("drained_full", int'(bus.full), 0);
    check("hold_rd_valid", int'(bus.rd_valid), 0);
    check("hold_rd_data", int'(bus.rd_data), 1);

    // Write rejected while draining
    do_write(10);
    do_write(20);
    do_write(30);
    do_write(40);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'sd9;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    check("drain_wr_err", int'(bus.wr_err), 1);
    check("drain_wr_count", int'(bus.count), 4);
    @(negedge clk);
    check("wr_err_pulse_end", int'(bus.wr_err), 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'sd9;
    do_read(10);
    bus.wr_en   = 1'b0;
    check("both_drain_wr_err", int'(bus.wr_err), 1);
    check("both_drain_count", int'(bus.count), 3);
    do_read(20);
    do_read(30);
    do_read(40);
    @(negedge clk);
    check("drain2_count", int'(bus.count), 0);

    // Read ignored while filling
    do_write(11);
    do_write(12);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("fill_rd_count", int'(bus.count), 2);
    check("fill_rd_valid", int'(bus.rd_valid), 0);
    check("fill_rd_data", int'(bus.rd_data), 40);
    bus.rd_en = 1'b1;
    do_write(13);
    bus.rd_en = 1'b0;
    check("both_fill_count", int'(bus.count), 3);
    check("both_fill_rd_valid", int'(bus.rd_valid), 0);
    do_write(14);
    check("fill_full2", int'(bus.full), 1);
    do_read(11);
    do_read(12);
    do_read(13);
    do_read(14);
    @(negedge clk);

    // clr mid-drain, next fill restarts at entry 0
    do_write(1);
    do_write(2);
    do_write(3);
    do_write(4);
    do_read(1);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_count", int'(bus.count), 0);
    check("clr_full", int'(bus.full), 0);
    check("clr_empty", int'(bus.empty), 1);
    check("clr_rd_valid", int'(bus.rd_valid), 0);
    do_write(100);
    do_write(200);
    do_write(300);
    do_write(400);
    do_read(100);
    do_read(200);
    @(negedge clk);

    // Asynchronous reset mid-drain
    rst = 1'b1;
    #1;
    check("arst_count", int'(bus.count), 0);
    check("arst_full", int'(bus.full), 0);
    check("arst_empty", int'(bus.empty), 1);
    check("arst_rd_data", int'(bus.rd_data), 0);
    check("arst_rd_valid", int'(bus.rd_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    do_write(55);
    do_write(66);
    do_write(77);
    do_write(88);
    do_read(55);
    do_read(66);
    do_read(77);
    do_read(88);
    @(negedge clk);

`ifdef REG_BANK_MAX_EN
    do_reset();
    check("max_rst", int'(bus.max_out), -32768);
    do_write(-32768);
    do_write(-5);
    do_write(300);
    do_write(12);
    check("max_fill1", int'(bus.max_out), 300);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("max_clr", int'(bus.max_out), -32768);
    do_write(-7);
    do_write(-9);
    do_write(-2);
    do_write(-8);
    check("max_fill2", int'(bus.max_out), -2);
    do_read(-7);
    check("max_hold_drain", int'(bus.max_out), -2);
    do_read(-9);
    do_read(-2);
    do_read(-8);
    @(negedge clk);
`endif

    @(negedge clk);
    check("reads_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
